uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Byte buffer and transmit sequencer between the host/bus side and the UART transmitter.
- Accepts bytes from the host and stores them in a circular FIFO.
- Presents one byte at a time to the transmitter with a one-cycle enable pulse, then waits for the transmitter's done strobe before releasing the next byte.
- Removes the host's need to track transmitter busy state.

Parameters:
- DEPTH, 16, number of byte entries; power of two, ≥2.
- AW, 4, pointer width, log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr  input  1  host push strobe; one byte per cycle while high.
- wdata  input  8  byte to push, sampled when wr=1.
- full  output  1  count==DEPTH (combinational from count).
- empty  output  1  count==0 (combinational from count).
- count  output  AW+1  bytes currently stored. Excludes the byte handed to the transmitter.
- overflow  output  1  one-cycle pulse: push attempted while full.
- busy  output  1  high in SEND and WAIT states.
- tx_en  output  1  registered one-cycle pulse to the transmitter's write enable.
- tx_data  output  8  registered byte to the transmitter's data input; stable from SEND until next pop.
- tx_done  input  1  transmitter completion strobe (stop bit finished).

Behaviour:
- Reset (rst=1 at edge):
  - wr_ptr=0, rd_ptr=0, count=0, state=IDLE.
  - tx_en=0, tx_data=8'h00, overflow=0, busy=0.
  - Storage contents don't care.
  - Reset mid-transfer flushes all pending bytes; no tx_en follows reset until a new push.
- Push:
  - wr=1 and count<DEPTH: mem[wr_ptr]<=wdata, wr_ptr+1 (wraps modulo DEPTH).
  - wr=1 and count==DEPTH: byte dropped, pointers unchanged, overflow=1 for the next cycle.
  - The full check uses the pre-edge count, even if a pop happens in the same cycle.
- Pop: occurs only on the IDLE->SEND transition. tx_data<=mem[rd_ptr], rd_ptr+1 (wraps).
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- FSM:
  - IDLE: if count!=0, pop at this edge and go to SEND; otherwise stay.
  - SEND: tx_en=1 for exactly this cycle; unconditionally go to WAIT.
  - WAIT: stay until tx_done=1 is sampled, then go to IDLE.
- tx_done sampled outside WAIT is ignored. The transmitter's done strobe must arrive at least one cycle after tx_en.
- Latency:
  - Push at edge N into an empty idle block: count=1 in cycle N+1, pop at edge N+1, tx_en=1 in cycle N+2.
  - Back-to-back with data queued: tx_done in WAIT at edge M gives IDLE in M+1, pop at edge M+1, tx_en in M+2. Minimum 2-cycle gap from done to next enable.
- Ordering: strict FIFO. Bytes leave in push order with no duplication or loss, except bytes dropped on overflow.
- Boundaries:
  - Pointer wrap is transparent.
  - A push while empty but busy just queues.
  - Draining to empty in IDLE leaves tx_en low.
  - Push plus pop in the same cycle with count==1 keeps count=1.

Test Plan:
- Reset then single push wdata=8'hA5 at edge 0 -> tx_en high exactly in cycle 2, tx_data=8'hA5, busy=1, count=0. tx_done pulse in WAIT -> busy=0 two cycles later, no further tx_en.
- Push 8'h01..8'h05 back-to-back, tx_done every 20 cycles -> five tx_en pulses carrying 01,02,03,04,05 in order. Each pulse comes 2 cycles after the preceding tx_done. count peaks at 4.
- With transmitter stalled (tx_done=0), push 17 bytes 8'h10..8'h20 -> byte 8'h10 moves to tx_data, bytes 11..20 fill 16 entries. full=1 after the 17th push, no overflow pulse. An 18th push of 8'hFF -> overflow pulse of 1 cycle, 8'hFF never transmitted.
- Wrap: 40 bytes through a DEPTH=16 buffer with random push gaps and tx_done delays -> output sequence equals input sequence. count never exceeds 16.
- tx_done pulses while IDLE and during SEND -> ignored: no state change, no extra pop.
- Assert rst for 1 cycle while in WAIT with 6 bytes queued -> next cycle count=0, empty=1, busy=0, tx_en=0, tx_data=00. No tx_en until a new push, which is then sent as in the first scenario.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers host pushes and hands bytes out
// one at a time with a tx_en pulse, waiting for tx_done between bytes.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [7:0]    wdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          busy,
  output logic          tx_en,
  output logic [7:0]    tx_data,
  input  logic          tx_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic          push;
  logic          pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign busy  = (state != IDLE);

  // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot for the push.
  assign push = wr & ~full;
  assign pop  = (state == IDLE) & ~empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= IDLE;
      tx_en    <= 1'b0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr & full;
      tx_en    <= pop;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr];
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // tx_done only matters in WAIT; strobes seen in IDLE or SEND are dropped.
      case (state)
        IDLE:    if (pop) state <= SEND;
        SEND:    state <= WAIT;
        WAIT:    if (tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
